// File: rtl/neo_video_pkg.sv
// Shared constants, the delayed timing/colour bundle and the saturating line
// counter step for the video output timing block.
package neo_video_pkg;

  localparam int unsigned ACTIVE_W     = 320;
  localparam int unsigned HCNT_MAX     = 511;
  localparam int unsigned LINE_CNT_MAX = 1023;
  localparam int unsigned NTSC_LINES   = 264;
  localparam int unsigned PAL_LINES    = 312;

  // Everything that must stay aligned with the palette lookup latency.
  typedef struct packed {
    logic        hblank;
    logic        vblank;
    logic        hs;
    logic        vs;
    logic [15:0] pix;
  } vid_bundle_t;

  // Blanked, sync inactive, black.
  localparam vid_bundle_t VID_RESET = '{hblank: 1'b1, vblank: 1'b1,
                                        hs: 1'b1, vs: 1'b1, pix: 16'h0000};

  function automatic logic [9:0] line_inc(input logic [9:0] v);
    return (v == 10'(LINE_CNT_MAX)) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/neo_video_out_timing_if.sv
// MiSTer-facing video timing bus.
//   CE_PIXEL  pixel enable for the scaler
//   HBLANK    horizontal blank, active high
//   VBLANK    vertical blank, active high
//   HS, VS    active-low syncs
//   CSYNC     composite sync (HS XNOR VS)
//   PIX_OUT   colour, zero while blanked
// master = timing generator, slave = framework consumer.
interface neo_video_out_timing_if;

  logic        CE_PIXEL;
  logic        HBLANK;
  logic        VBLANK;
  logic        HS;
  logic        VS;
  logic        CSYNC;
  logic [15:0] PIX_OUT;

  modport master (
    output CE_PIXEL, HBLANK, VBLANK, HS, VS, CSYNC, PIX_OUT
  );

  modport slave (
    input CE_PIXEL, HBLANK, VBLANK, HS, VS, CSYNC, PIX_OUT
  );

endinterface

// File: rtl/neo_ce_delay.sv
// Enable-gated shift register.
//   CLK, nRESETP  clock, asynchronous active-low reset
//   CE            shift enable
//   RST_VAL       value loaded into every stage on reset
//   D, Q          input, output after DEPTH enables
module neo_ce_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             CLK,
  input  logic             nRESETP,
  input  logic             CE,
  input  logic [WIDTH-1:0] RST_VAL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (CE) begin
      stage[0] <= D;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign Q = stage[DEPTH-1];

endmodule

// File: rtl/neo_video_out_timing.sv
// Video output timing: turns the LSPC pixel-rate sync/blank/colour into
// delay-aligned MiSTer timing, applies the optional 304-pixel crop and
// measures lines per frame.
//   CLK, nRESETP      clock, asynchronous active-low reset
//   CLK_EN_6M         pixel enable; all sampling happens on it
//   HSYNC_IN/VSYNC_IN active-low syncs from the sync stage
//   BNK, CHBL         vertical display window, horizontal blank
//   CROP_304          1 = 304-pixel visible width
//   PIX_IN            palette colour
//   vid               timing/colour bus to the framework
//   LINES_PER_FRAME   lines in the last complete frame
//   FRAME_STABLE      last two frame counts equal and nonzero
//   FRAME_CNT         complete frames since reset (wraps)
module neo_video_out_timing
  import neo_video_pkg::*;
#(
  parameter int unsigned PIPE_DLY    = 2,
  parameter int unsigned CROP_MARGIN = 8
) (
  input  logic                  CLK,
  input  logic                  nRESETP,
  input  logic                  CLK_EN_6M,
  input  logic                  HSYNC_IN,
  input  logic                  VSYNC_IN,
  input  logic                  BNK,
  input  logic                  CHBL,
  input  logic                  CROP_304,
  input  logic [15:0]           PIX_IN,
  neo_video_out_timing_if.master vid,
  output logic [9:0]            LINES_PER_FRAME,
  output logic                  FRAME_STABLE,
  output logic [7:0]            FRAME_CNT
);

  logic        hs_prev, vs_prev, chbl_prev;
  logic [8:0]  hcnt, hcnt_nx;
  logic        crop_l, crop_nx;
  logic [9:0]  linecnt, lines_now;
  logic        seen_vs;
  logic        hfall, vfall;
  logic        hblank_raw;
  vid_bundle_t dly_in, dly_out;

  assign hfall = hs_prev & ~HSYNC_IN;
  assign vfall = vs_prev & ~VSYNC_IN;

  // Position of the pixel presented on this enable, so the first active
  // pixel after the CHBL fall is already hcnt 0 when the blank is formed.
  always_comb begin
    hcnt_nx = hcnt;
    crop_nx = crop_l;
    if (!CHBL) begin
      if (chbl_prev) begin
        hcnt_nx = '0;
        crop_nx = CROP_304;
      end else if (hcnt != 9'(HCNT_MAX)) begin
        hcnt_nx = hcnt + 9'd1;
      end
    end
  end

  assign hblank_raw = CHBL | (crop_nx & ((hcnt_nx < 9'(CROP_MARGIN)) |
                      (hcnt_nx >= 9'(ACTIVE_W - CROP_MARGIN))));

  // An HSYNC fall coinciding with the VSYNC fall counts in both frames.
  assign lines_now = hfall ? line_inc(linecnt) : linecnt;

  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      hs_prev         <= 1'b1;
      vs_prev         <= 1'b1;
      chbl_prev       <= 1'b1;
      hcnt            <= '0;
      crop_l          <= 1'b0;
      linecnt         <= '0;
      seen_vs         <= 1'b0;
      LINES_PER_FRAME <= '0;
      FRAME_STABLE    <= 1'b0;
      FRAME_CNT       <= '0;
    end else if (CLK_EN_6M) begin
      hs_prev   <= HSYNC_IN;
      vs_prev   <= VSYNC_IN;
      chbl_prev <= CHBL;
      hcnt      <= hcnt_nx;
      crop_l    <= crop_nx;
      if (vfall) begin
        if (seen_vs) begin
          LINES_PER_FRAME <= lines_now;
          FRAME_STABLE    <= (lines_now == LINES_PER_FRAME) && (lines_now != '0);
          FRAME_CNT       <= FRAME_CNT + 8'd1;
        end
        linecnt <= hfall ? 10'd1 : 10'd0;
        seen_vs <= 1'b1;
      end else if (hfall) begin
        linecnt <= line_inc(linecnt);
      end
    end
  end

  assign dly_in = '{hblank: hblank_raw, vblank: ~BNK, hs: HSYNC_IN,
                    vs: VSYNC_IN, pix: PIX_IN};

  neo_ce_delay #(
    .WIDTH($bits(vid_bundle_t)),
    .DEPTH(PIPE_DLY)
  ) u_dly (
    .CLK     (CLK),
    .nRESETP (nRESETP),
    .CE      (CLK_EN_6M),
    .RST_VAL (VID_RESET),
    .D       (dly_in),
    .Q       (dly_out)
  );

  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      vid.CE_PIXEL <= 1'b0;
      vid.HBLANK   <= 1'b1;
      vid.VBLANK   <= 1'b1;
      vid.HS       <= 1'b1;
      vid.VS       <= 1'b1;
      vid.CSYNC    <= 1'b1;
      vid.PIX_OUT  <= '0;
    end else begin
      vid.CE_PIXEL <= CLK_EN_6M;
      vid.HBLANK   <= dly_out.hblank;
      vid.VBLANK   <= dly_out.vblank;
      vid.HS       <= dly_out.hs;
      vid.VS       <= dly_out.vs;
      vid.CSYNC    <= ~(dly_out.hs ^ dly_out.vs);
      vid.PIX_OUT  <= (dly_out.hblank | dly_out.vblank) ? 16'h0000 : dly_out.pix;
    end
  end

endmodule

// File: doc/neo_video_out_timing.md
Name: neo_video_out_timing

Overview:
- Downstream consumer of the LSPC video sync stage.
- Takes the raw pixel-rate sync, blanking and colour signals and produces MiSTer-facing video timing: pixel enable, HBLANK/VBLANK, HS/VS/CSYNC and pixel colour, all delay-aligned.
- Applies optional 304-pixel horizontal crop.
- Measures lines per frame and reports a stable PAL/NTSC frame status to the framework.

Parameters:
- PIPE_DLY, 2: pixel-enable delay (1..4) applied to all timing outputs, matching palette RAM lookup latency.
- CROP_MARGIN, 8: pixels blanked at each edge of the 320-pixel window in crop mode.

Ports:
- CLK  in  1  system clock.
- nRESETP  in  1  asynchronous active-low reset.
- CLK_EN_6M  in  1  one-CLK pixel enable; all sampling and shifting occurs only on this enable.
- HSYNC_IN  in  1  active-low horizontal sync from the sync stage.
- VSYNC_IN  in  1  active-low vertical sync from the sync stage.
- BNK  in  1  high during the vertical display window.
- CHBL  in  1  high during horizontal blank.
- CROP_304  in  1  1 = 304-pixel visible width; 0 = 320.
- PIX_IN  in  16  palette colour for the current pixel (dark bit + RGB555).
- CE_PIXEL  out  1  copy of CLK_EN_6M, registered one CLK.
- HBLANK  out  1  horizontal blank, active high.
- VBLANK  out  1  vertical blank, active high.
- HS  out  1  active-low horizontal sync.
- VS  out  1  active-low vertical sync.
- CSYNC  out  1  composite sync, HS XNOR VS.
- PIX_OUT  out  16  delayed colour, forced 0 while blanked.
- LINES_PER_FRAME  out  10  line count of the last complete frame.
- FRAME_STABLE  out  1  two consecutive equal nonzero frame counts.
- FRAME_CNT  out  8  complete frames since reset, wrapping.

Behaviour:
- Reset (async): HBLANK=1, VBLANK=1, HS=1, VS=1, CSYNC=1, PIX_OUT=0, CE_PIXEL=0, LINES_PER_FRAME=0, FRAME_STABLE=0, FRAME_CNT=0.
- Reset also clears all internal counters and delay stages. Delay stages reset to the blanked/sync-inactive values above.
- Input capture on CLK_EN_6M: register HSYNC_IN, VSYNC_IN, CHBL and the previous values needed for edge detection.
- hcnt (9 bit):
  - Cleared on a CHBL 1->0 edge; increments each enable while CHBL=0; saturates at 511.
  - CROP_304 is latched into crop_l on the same 1->0 edge, so a mid-line change takes effect on the next line.
- Raw horizontal blank = CHBL OR (crop_l AND (hcnt < CROP_MARGIN OR hcnt >= 320-CROP_MARGIN)).
- Raw vertical blank = NOT BNK.
- Delay: raw hblank, vblank, HSYNC_IN, VSYNC_IN and PIX_IN all pass through the same PIPE_DLY-stage enable-gated shift. Output relation to input is exactly PIPE_DLY enables plus one CLK.
- PIX_OUT = delayed PIX_IN when both delayed blanks are 0, else 0.
- CSYNC is computed from the delayed HS/VS.
- Line measurement (undelayed inputs):
  - linecnt (10 bit) increments on each HSYNC_IN 1->0 edge; saturates at 1023.
  - On a VSYNC_IN 1->0 edge, if seen_vs=1:
    - LINES_PER_FRAME <= linecnt (+1 if an HSYNC fall occurs on the same enable).
    - FRAME_STABLE <= (new value == previous LINES_PER_FRAME) AND new value != 0.
    - FRAME_CNT increments.
  - On every VSYNC_IN 1->0 edge, linecnt clears (to 1 if a simultaneous HSYNC fall occurs) and seen_vs is set.
  - The first VSYNC fall after reset only sets seen_vs and clears linecnt. A partial frame is never reported.
- Expected counts: NTSC 264, PAL 312. The block does not interpret VMODE.
- No enable for 4096 CLKs or more: outputs hold their values; no timeout.

Decomposition:
- Package neo_video_pkg holds:
  - ACTIVE_W = 320.
  - HCNT_MAX = 511.
  - LINE_CNT_MAX = 1023.
  - NTSC_LINES = 264.
  - PAL_LINES = 312.
- Sub-module neo_ce_delay: parameterised width and depth, enable-gated shift register with async reset value input. It is instantiated once for the combined 20-bit timing/colour bundle.

Test Plan:
- Reset asserted mid-line, then released → all outputs hold reset values. LINES_PER_FRAME stays 0 until the second VSYNC fall after release.
- Three NTSC frames (264 HSYNC falls per VSYNC) → LINES_PER_FRAME=264; FRAME_STABLE=1 after the second complete frame; FRAME_CNT=2.
- Switch from PAL (312) to NTSC mid-run → first report 312 with stable=1; next report 264 with stable=0; the report after that 264 with stable=1.
- CROP_304=1 with a 320-enable CHBL-low window → HBLANK low for exactly 304 enables, starting 8 enables after the window opens. Toggling CROP_304 mid-line has no effect until the next line.
- PIPE_DLY=2, single pixel PIX_IN=16'h7FFF in active video → PIX_OUT=7FFF exactly 2 enables (+1 CLK) later. Otherwise PIX_OUT=0 while blanked.
- HSYNC and VSYNC fall on the same enable after 263 prior HSYNC falls → LINES_PER_FRAME=264 and next-frame linecnt starts at 1. CSYNC=0 only when exactly one of HS/VS is low.
